// File: rtl/sprdma.sv
// Sprite DMA engine: a CPU write to 16'h4014 copies the 256-byte page {page, 00..FF}
// into the PPU OAM data port at 16'h2004, taking the CPU bus for 513 cycles.
module sprdma (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] cpu_a_in,
  input  logic [7:0]  cpu_d_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  mem_d_in,
  output logic        active_out,
  output logic [15:0] mem_a_out,
  output logic [7:0]  mem_d_out,
  output logic        mem_r_nw_out
);

  localparam logic [15:0] TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [1:0] {
    IDLE,
    COOLDOWN,
    READ,
    WRITE
  } state_t;

  state_t      state;
  logic [7:0]  page;
  logic [7:0]  index;
  logic [7:0]  data;
  logic        trigger;
  logic        last_byte;
  logic [7:0]  next_index;

  assign trigger    = (cpu_a_in == TRIGGER_ADDR) && !cpu_r_nw_in;
  assign last_byte  = (index == 8'hFF);
  assign next_index = index + 8'd1;

  // Outputs are loaded with the values belonging to the state being entered,
  // so the bus always reflects the current state straight from flops.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      page         <= 8'h00;
      index        <= 8'h00;
      data         <= 8'h00;
      active_out   <= 1'b0;
      mem_a_out    <= 16'h0000;
      mem_d_out    <= 8'h00;
      mem_r_nw_out <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          active_out   <= 1'b0;
          mem_a_out    <= 16'h0000;
          mem_d_out    <= 8'h00;
          mem_r_nw_out <= 1'b1;
          if (trigger) begin
            page       <= cpu_d_in;
            index      <= 8'h00;
            active_out <= 1'b1;
            state      <= COOLDOWN;
          end
        end

        // One dead cycle so the CPU's own write to 16'h4014 can retire.
        COOLDOWN: begin
          mem_a_out    <= {page, index};
          mem_r_nw_out <= 1'b1;
          state        <= READ;
        end

        READ: begin
          data         <= mem_d_in;
          mem_d_out    <= mem_d_in;
          mem_a_out    <= OAM_DATA_ADDR;
          mem_r_nw_out <= 1'b0;
          state        <= WRITE;
        end

        WRITE: begin
          if (last_byte) begin
            index        <= 8'h00;
            active_out   <= 1'b0;
            mem_a_out    <= 16'h0000;
            mem_d_out    <= 8'h00;
            mem_r_nw_out <= 1'b1;
            state        <= IDLE;
          end else begin
            index        <= next_index;
            mem_a_out    <= {page, next_index};
            mem_d_out    <= data;
            mem_r_nw_out <= 1'b1;
            state        <= READ;
          end
        end

        default: begin
          active_out   <= 1'b0;
          mem_a_out    <= 16'h0000;
          mem_d_out    <= 8'h00;
          mem_r_nw_out <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprdma.sv
// Randomized bench for sprdma: a transfer is modelled as a 513-slot timeline
// (slot 0 cooldown, odd slots read {page, n}, even slots write mem[{page, n}] to 2004).
module tb_sprdma;

  logic        clk_in;
  logic        rst_in;
  logic [15:0] cpu_a_in;
  logic [7:0]  cpu_d_in;
  logic        cpu_r_nw_in;
  logic [7:0]  mem_d_in;
  logic        active_out;
  logic [15:0] mem_a_out;
  logic [7:0]  mem_d_out;
  logic        mem_r_nw_out;

  logic [7:0] mem [0:65535];

  int checkCount = 0;
  int errorCount = 0;

  logic       mActive = 1'b0;
  int         mSlot = 0;
  logic [7:0] mPage = 8'h00;

  int   runLen = 0;
  int   runWrites = 0;
  logic prevActive = 1'b0;

  sprdma dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .cpu_a_in    (cpu_a_in),
    .cpu_d_in    (cpu_d_in),
    .cpu_r_nw_in (cpu_r_nw_in),
    .mem_d_in    (mem_d_in),
    .active_out  (active_out),
    .mem_a_out   (mem_a_out),
    .mem_d_out   (mem_d_out),
    .mem_r_nw_out(mem_r_nw_out)
  );

  assign mem_d_in = mem[mem_a_out];

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkCycle();
    logic [7:0] n;
    if (!mActive) begin
      checkOutput("idle_active", 32'(active_out), 32'd0);
      checkOutput("idle_addr", 32'(mem_a_out), 32'h0000);
      checkOutput("idle_data", 32'(mem_d_out), 32'h00);
      checkOutput("idle_rnw", 32'(mem_r_nw_out), 32'd1);
    end else begin
      checkOutput("xfer_active", 32'(active_out), 32'd1);
      if (mSlot == 0) begin
        checkOutput("cooldown_addr", 32'(mem_a_out), 32'h0000);
        checkOutput("cooldown_rnw", 32'(mem_r_nw_out), 32'd1);
      end else if (mSlot % 2 == 1) begin
        n = 8'((mSlot - 1) / 2);
        checkOutput("read_addr", 32'(mem_a_out), 32'({mPage, n}));
        checkOutput("read_rnw", 32'(mem_r_nw_out), 32'd1);
      end else begin
        n = 8'((mSlot - 2) / 2);
        checkOutput("write_addr", 32'(mem_a_out), 32'h2004);
        checkOutput("write_rnw", 32'(mem_r_nw_out), 32'd0);
        checkOutput("write_data", 32'(mem_d_out), 32'(mem[{mPage, n}]));
      end
    end
    if (active_out) begin
      runLen++;
      if (!mem_r_nw_out && mem_a_out == 16'h2004) runWrites++;
    end else if (prevActive) begin
      checkOutput("xfer_cycles", 32'(runLen), 32'd513);
      checkOutput("xfer_bytes", 32'(runWrites), 32'd256);
      runLen = 0;
      runWrites = 0;
    end
    prevActive = active_out;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    cpu_a_in = a;
    cpu_d_in = d;
    cpu_r_nw_in = rnw;
    @(posedge clk_in);
    if (!rst_in) begin
      mActive = 1'b0;
    end else if (mActive) begin
      mSlot++;
      if (mSlot == 513) mActive = 1'b0;
    end else if (a == 16'h4014 && !rnw) begin
      mActive = 1'b1;
      mSlot = 0;
      mPage = d;
    end
    #1;
    checkCycle();
  endtask

  task automatic idleNoise(input int cycles);
    logic [15:0] a;
    logic        rnw;
    for (int i = 0; i < cycles; i++) begin
      a = 16'($urandom);
      rnw = 1'($urandom);
      if (a == 16'h4014) rnw = 1'b1;
      applyStimulus(a, 8'($urandom), rnw);
    end
  endtask

  task automatic busyNoise();
    if ($urandom_range(0, 15) == 0)
      applyStimulus(16'h4014, 8'($urandom), 1'b0);
    else
      applyStimulus(16'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic runTransfer(input logic [7:0] page, input int retrigSlot, input int stopSlot);
    int guard;
    applyStimulus(16'h4014, page, 1'b0);
    guard = 0;
    while (mActive && mSlot != stopSlot && guard < 600) begin
      if (mSlot == retrigSlot) applyStimulus(16'h4014, 8'h07, 1'b0);
      else busyNoise();
      guard++;
    end
  endtask

  task automatic assertResetNow();
    rst_in = 1'b0;
    mActive = 1'b0;
    runLen = 0;
    runWrites = 0;
    prevActive = 1'b0;
    #1;
    checkOutput("rst_active", 32'(active_out), 32'd0);
    checkOutput("rst_addr", 32'(mem_a_out), 32'h0000);
    checkOutput("rst_data", 32'(mem_d_out), 32'h00);
    checkOutput("rst_rnw", 32'(mem_r_nw_out), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    cpu_a_in = 16'h0000;
    cpu_d_in = 8'h00;
    cpu_r_nw_in = 1'b1;
    rst_in = 1'b1;
    #2;
    assertResetNow();
    applyStimulus(16'h4014, 8'h09, 1'b0);
    applyStimulus(16'h4014, 8'h09, 1'b0);
    rst_in = 1'b1;

    idleNoise(10);
    applyStimulus(16'h4014, 8'h02, 1'b1);
    applyStimulus(16'h4015, 8'h02, 1'b0);
    idleNoise(3);

    runTransfer(8'h02, 100, -1);
    runTransfer(8'h03, -1, -1);
    idleNoise(5);
    runTransfer(8'h20, -1, -1);
    idleNoise(2);

    runTransfer(8'h02, -1, 130);
    #2;
    assertResetNow();
    applyStimulus(16'h4014, 8'h11, 1'b0);
    applyStimulus(16'h4014, 8'h11, 1'b0);
    rst_in = 1'b1;
    idleNoise(20);

    rst_in = 1'b0;
    applyStimulus(16'h0000, 8'h00, 1'b1);
    rst_in = 1'b1;
    runTransfer(8'h05, -1, -1);
    idleNoise(5);

    checkOutput("final_idle", 32'(active_out), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
